// File: rtl/batt_disp_pkg.sv
// batt_disp_pkg: shared types and defaults for the battery display feeder.
package batt_disp_pkg;
  typedef enum logic {POWERUP = 1'b0, RUN = 1'b1} state_t;
  localparam logic CH_BATT1 = 1'b0;
  localparam logic CH_BATT2 = 1'b1;
  localparam int AVG_LOG2_DEF = 3;
  localparam int POWERUP_CYCLES_DEF = 2_500_000;
  localparam int SAMPLE_W_DEF = 16;
endpackage

// File: rtl/battery_sample_averager_if.sv
// battery_sample_averager_if: valid/ready sample stream carrying a channel tag.
interface battery_sample_averager_if #(
  parameter int SAMPLE_W = 16
) ();
  logic                valid;
  logic                ready;
  logic                chan;
  logic [SAMPLE_W-1:0] data;
  modport master (output valid, chan, data, input ready);
  modport slave (input valid, chan, data, output ready);
endinterface

// File: rtl/battery_sample_averager_channel_averager.sv
// channel_averager: windowed average of one channel, registered output slice plus done pulse.
module channel_averager #(
  parameter int SAMPLE_W = 16,
  parameter int AVG_LOG2 = 3,
  parameter int OUT_LSB  = 0,
  parameter int OUT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                accept,
  input  logic [SAMPLE_W-1:0] data,
  output logic [OUT_W-1:0]    avg,
  output logic                done
);
  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [AVG_LOG2-1:0] cnt;
  // accumulator is sized so a full window of max samples still fits
  assign sum = acc + {{AVG_LOG2{1'b0}}, data};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc  <= '0;
      cnt  <= '0;
      avg  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && &cnt) begin
        avg  <= sum[AVG_LOG2+OUT_LSB +: OUT_W];
        acc  <= '0;
        cnt  <= '0;
        done <= 1'b1;
      end else if (accept) begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: rtl/battery_sample_averager.sv
// battery_sample_averager: LCD power-up delay plus per-channel battery averaging for the status display.
module battery_sample_averager
  import batt_disp_pkg::*;
#(
  parameter int AVG_LOG2       = AVG_LOG2_DEF,
  parameter int POWERUP_CYCLES = POWERUP_CYCLES_DEF,
  parameter int SAMPLE_W       = SAMPLE_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  battery_sample_averager_if.slave   s,
  output logic                       ready_o,
  output logic [15:0]                number1,
  output logic [3:0]                 number2,
  output logic                       update_o
);
  localparam int CNT_W = POWERUP_CYCLES > 1 ? $clog2(POWERUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  state_t           state;
  logic [CNT_W-1:0] pwr_cnt;
  logic             rdy;
  logic             acc0, acc1, done0, done1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= POWERUP;
      pwr_cnt <= '0;
      rdy     <= 1'b0;
    end else if (state == POWERUP) begin
      pwr_cnt <= pwr_cnt + 1'b1;
      if (pwr_cnt == PWR_LAST) begin
        state <= RUN;
        rdy   <= 1'b1;
      end
    end
  assign s.ready = rdy;
  assign ready_o = rdy;
  assign acc0 = s.valid && rdy && s.chan == CH_BATT1;
  assign acc1 = s.valid && rdy && s.chan == CH_BATT2;
  channel_averager #(
    .SAMPLE_W(SAMPLE_W), .AVG_LOG2(AVG_LOG2), .OUT_LSB(0), .OUT_W(16)
  ) u_batt1 (
    .clk(clk), .reset(reset), .accept(acc0), .data(s.data), .avg(number1), .done(done0)
  );
  // only the top nibble of battery 2 is kept, as a 0..15 level
  channel_averager #(
    .SAMPLE_W(SAMPLE_W), .AVG_LOG2(AVG_LOG2), .OUT_LSB(SAMPLE_W - 4), .OUT_W(4)
  ) u_batt2 (
    .clk(clk), .reset(reset), .accept(acc1), .data(s.data), .avg(number2), .done(done1)
  );
  assign update_o = done0 | done1;
endmodule

// File: tb/tb_battery_sample_averager.sv
// tb_battery_sample_averager: directed plus random checks against a queue-based averaging model.
module tb_battery_sample_averager;
  localparam int A  = 2;
  localparam int PC = 10;
  localparam int W  = 1 << A;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ready_o, update_o;
  logic [15:0] number1;
  logic [3:0]  number2;
  int checks = 0;
  int errors = 0;
  int q [2][$];
  logic [15:0] exp_n1 = '0;
  logic [3:0]  exp_n2 = '0;
  battery_sample_averager_if #(.SAMPLE_W(16)) bus ();
  battery_sample_averager #(.AVG_LOG2(A), .POWERUP_CYCLES(PC), .SAMPLE_W(16)) dut (
    .clk(clk), .reset(reset), .s(bus.slave), .ready_o(ready_o),
    .number1(number1), .number2(number2), .update_o(update_o)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic outs(input string tag, input logic upd);
    chk({tag, " update_o"}, {31'd0, update_o}, {31'd0, upd});
    chk({tag, " number1"}, {16'd0, number1}, {16'd0, exp_n1});
    chk({tag, " number2"}, {28'd0, number2}, {28'd0, exp_n2});
  endtask

  // behavioural model: collect a window, average it with plain division
  task automatic send(input logic ch, input logic [15:0] d, input string tag);
    longint sum;
    logic upd;
    @(negedge clk);
    bus.valid = 1'b1; bus.chan = ch; bus.data = d;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    q[ch].push_back(int'(d));
    upd = 1'b0;
    if (q[ch].size() == W) begin
      sum = 0;
      foreach (q[ch][i]) sum += q[ch][i];
      sum = sum / W;
      if (ch) exp_n2 = 4'(sum / 4096);
      else exp_n1 = 16'(sum);
      q[ch].delete();
      upd = 1'b1;
    end
    outs(tag, upd);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    bus.valid = 1'b0;
    @(posedge clk); #1;
    outs(tag, 1'b0);
  endtask

  task automatic powerup(input string tag);
    @(negedge clk);
    reset = 1'b1;
    bus.valid = 1'b1; bus.chan = 1'b0; bus.data = 16'd5000;
    for (int k = 1; k <= PC; k++) begin
      @(posedge clk); #1;
      chk({tag, " ready_o"}, {31'd0, ready_o}, {31'd0, k == PC});
      chk({tag, " s_ready"}, {31'd0, bus.ready}, {31'd0, k == PC});
      outs(tag, 1'b0);
      bus.data = 16'($urandom);
      if (k == PC) bus.valid = 1'b0;
    end
  endtask

  initial begin
    bus.valid = 1'b0; bus.chan = 1'b0; bus.data = '0;
    #1;
    chk("reset ready_o", {31'd0, ready_o}, 32'd0);
    chk("reset s_ready", {31'd0, bus.ready}, 32'd0);
    outs("reset", 1'b0);
    repeat (2) @(posedge clk);
    powerup("powerup1");
    idle("idle after powerup");
    send(1'b0, 16'd100, "t2 s0"); send(1'b0, 16'd200, "t2 s1");
    send(1'b0, 16'd300, "t2 s2"); send(1'b0, 16'd400, "t2 s3");
    chk("t2 number1 250", {16'd0, number1}, 32'd250);
    idle("t2 pulse ends");
    repeat (W) send(1'b1, 16'hFFFF, "t3 full");
    chk("t3 number2 15", {28'd0, number2}, 32'd15);
    repeat (W) send(1'b1, 16'h1FFF, "t3 1fff");
    chk("t3 number2 1", {28'd0, number2}, 32'd1);
    for (int i = 0; i < W; i++) begin
      send(1'b0, 16'(10 + i), "t4 ch0");
      send(1'b1, 16'h8000, "t4 ch1");
    end
    chk("t4 number1 11", {16'd0, number1}, 32'd11);
    chk("t4 number2 8", {28'd0, number2}, 32'd8);
    send(1'b0, 16'd1000, "t5 pre0"); send(1'b0, 16'd1000, "t5 pre1");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5 async ready_o", {31'd0, ready_o}, 32'd0);
    chk("t5 async number1", {16'd0, number1}, 32'd0);
    chk("t5 async number2", {28'd0, number2}, 32'd0);
    q[0].delete(); q[1].delete();
    exp_n1 = '0; exp_n2 = '0;
    powerup("powerup2");
    repeat (W) send(1'b0, 16'd8, "t5 post");
    chk("t5 number1 8", {16'd0, number1}, 32'd8);
    repeat (W) send(1'b0, 16'hFFFF, "t6 full");
    chk("t6 number1 65535", {16'd0, number1}, 32'd65535);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle("rand idle");
      else send(1'($urandom), 16'($urandom), "rand send");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/battery_sample_averager.md
# battery_sample_averager

Upstream feeder for the two-line LCD status display. It accepts raw 16-bit battery samples for two channels over a valid/ready stream and averages each channel over a fixed window. It holds the display values `number1` (16-bit) and `number2` (4-bit level) stable between window updates. It also generates the LCD power-up `ready_o` level that releases the display controller from IDLE.

## Interface

Parameters:
- `AVG_LOG2`, default 3: window length is 2^AVG_LOG2 samples per channel; legal range 1..8.
- `POWERUP_CYCLES`, default 2_500_000: clk cycles from reset release to `ready_o` (50 ms at 50 MHz); must be ≥ 1.
- `SAMPLE_W`, default 16: sample width.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low.
- `s_valid` in 1: sample present.
- `s_ready` out 1: block accepts a sample this cycle.
- `s_chan` in 1: 0 = battery 1, 1 = battery 2.
- `s_data` in SAMPLE_W: unsigned sample.
- `ready_o` out 1: LCD may start configuring; drives the controller's `ready_i`.
- `number1` out 16: averaged battery-1 value.
- `number2` out 4: battery-2 level, 0..15.
- `update_o` out 1: one-cycle pulse, high in the cycle `number1` or `number2` takes a new value.

## Operation

- The FSM has two states, POWERUP and RUN.
  - POWERUP: a counter runs from 0 to POWERUP_CYCLES-1. `s_ready` = 0 and `ready_o` = 0. On the terminal count the FSM moves to RUN.
  - RUN: `s_ready` = 1 and `ready_o` = 1. The FSM stays in RUN until reset.
- Transfer happens when `s_valid && s_ready`. While `s_ready` = 0, `s_valid` is ignored and the producer must hold its data.
- Each channel has its own accumulator, SAMPLE_W+AVG_LOG2 bits wide, and its own sample counter, AVG_LOG2 bits wide. Neither can overflow.
- On an accepted sample for channel c:
  - If the counter is below 2^AVG_LOG2-1: add the sample to the accumulator and increment the counter.
  - If this is the last sample of the window: the sum is acc+s_data. Shift the sum right by AVG_LOG2 (truncating) and load the result into the channel's output. Clear the accumulator and counter to 0, then pulse `update_o`.
- Channel 0 output: `number1` = average[15:0].
- Channel 1 output: `number2` = average[SAMPLE_W-1 -: 4], i.e. the top 4 bits.
- Only one sample is accepted per cycle, so both outputs never update in the same cycle. A window on one channel never disturbs the other channel's partial window.
- Between updates the outputs are stable. The LCD samples them asynchronously on its slow clock and must never see a partial value.

## Timing

- Reset values: `s_ready` = 0, `ready_o` = 0, `number1` = 0, `number2` = 0, `update_o` = 0. The FSM is in POWERUP and all counters and accumulators are 0.
- `ready_o` and `s_ready` rise together, POWERUP_CYCLES clk edges after reset deasserts, and stay high until reset.
- Output latency: the outputs and `update_o` change on the clk edge that accepts the window's final sample. They are registered and visible the following cycle. `update_o` lasts exactly one cycle.
- Reset mid-window: the partial sums are discarded. The outputs return to 0 and power-up restarts from 0. `ready_o` drops immediately because the reset is asynchronous.
- Full-scale input: all samples at 0xFFFF give `number1` = 65535 and `number2` = 15.
- All registers are clocked on posedge clk only. There are no derived clocks.

## Structure

- Shared package `batt_disp_pkg`:
  - FSM state encoding (POWERUP, RUN).
  - The channel index constants CH_BATT1 = 0 and CH_BATT2 = 1.
  - Default AVG_LOG2 and POWERUP_CYCLES.
- Sub-module `channel_averager`, instantiated twice:
  - Holds the accumulator, the counter and the output register.
  - Inputs: accept strobe and data. Outputs: average and done pulse.
- The top level contains the power-up FSM, channel demux, output slicing and the `update_o` OR.

## Test plan

Run with AVG_LOG2 = 2 and POWERUP_CYCLES = 10.
1. Release reset, keep `s_valid` = 1 → `s_ready` and `ready_o` stay 0 for 10 cycles, then go high. No sample offered before that is counted. The outputs remain 0.
2. Four ch0 samples 100, 200, 300, 400 → `number1` = 250 and one `update_o` pulse, on the edge accepting 400. `number2` is unchanged.
3. Four ch1 samples 0xFFFF → `number2` = 15. Four ch1 samples 0x1FFF → `number2` = 1.
4. Interleave ch0 samples 10, 11, 12, 13 with ch1 samples 0x8000 ×4 → `number1` = 11 and `number2` = 8, giving two separate `update_o` pulses.
5. Accept two ch0 samples of 1000, assert reset for 1 cycle, wait for power-up, then send four ch0 samples of 8 → `number1` = 8 with no contamination from the first samples.
6. Four ch0 samples of 0xFFFF → `number1` = 65535 with no wrap.
